decode_stage_hz: RTL and testbench

- Parametrised, registered successor of the MIPS decode stage.
- Holds the register file, decodes the opcode/function fields into control signals, and bypasses same-cycle write-back data into the read ports.
- Detects load-use hazards against the instruction currently in EX, and owns the ID/EX pipeline register.
- Sits between the IF/ID register and the execute stage. Outputs are one cycle after the instruction is presented.

---
 rtl/decode_pkg.sv | 77 +++++++
 rtl/decode_regfile.sv | 42 ++++
 rtl/decode_stage_hz.sv | 149 ++++++++++++++
 tb/tb_decode_stage_hz.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode/funct encodings, the control bundle layout
// and the opcode-to-control lookup used by the decode stage.
package decode_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_JALR  = 6'h09;

   typedef struct packed {
      logic       reg_write;
      logic       mem_to_reg;
      logic       jump;
      logic       branch;
      logic       branch_not;
      logic       mem_read;
      logic       mem_write;
      logic       reg_dst;
      logic       alu_src;
      logic [5:0] alu_op;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '0;

   function automatic ctrl_t decode_ctrl(input logic [5:0] op, input logic [5:0] funct);
      ctrl_t c;
      c        = CTRL_NOP;
      c.alu_op = op;
      case (op)
         OP_RTYPE: begin
            c.alu_op    = funct;
            c.reg_dst   = 1'b1;
            c.reg_write = (funct != FN_JR);
            c.jump      = (funct == FN_JR) || (funct == FN_JALR);
         end
         OP_J:    c.jump = 1'b1;
         OP_JAL: begin
            c.jump      = 1'b1;
            c.reg_write = 1'b1;
            c.reg_dst   = 1'b1;
         end
         OP_BEQ:  c.branch     = 1'b1;
         OP_BNE:  c.branch_not = 1'b1;
         OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: begin
            c.reg_write = 1'b1;
            c.alu_src   = 1'b1;
         end
         OP_LW: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
            c.mem_read   = 1'b1;
            c.alu_src    = 1'b1;
         end
         OP_SW: begin
            c.mem_write = 1'b1;
            c.alu_src   = 1'b1;
         end
         default: c = CTRL_NOP;
      endcase
      return c;
   endfunction

   // Instructions whose rt field is a source operand (not a destination).
   function automatic logic uses_rt(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
   endfunction

endpackage

// File: rtl/decode_regfile.sv
// 2**W x B register file, two read ports, r0 hardwired to zero, same-cycle
// write-back data forwarded into both read ports.
module decode_regfile
   import decode_pkg::*;
#(
   parameter int B = 32,
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         we,
   input  logic [W-1:0] waddr,
   input  logic [B-1:0] wdata,
   input  logic [W-1:0] raddr1,
   input  logic [W-1:0] raddr2,
   output logic [B-1:0] rdata1,
   output logic [B-1:0] rdata2
);

   logic [B-1:0] mem [2**W];
   logic         wr_live;

   assign wr_live = we && (waddr != '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 2**W; i++) mem[i] <= '0;
      end else if (wr_live) begin
         mem[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata1 = mem[raddr1];
      rdata2 = mem[raddr2];
      if (raddr1 == '0)                      rdata1 = '0;
      else if (wr_live && raddr1 == waddr)   rdata1 = wdata;
      if (raddr2 == '0)                      rdata2 = '0;
      else if (wr_live && raddr2 == waddr)   rdata2 = wdata;
   end

endmodule

// File: rtl/decode_stage_hz.sv
// Registered MIPS decode stage: register file, control decode, load-use hazard
// detection and the ID/EX pipeline register.
module decode_stage_hz
   import decode_pkg::*;
#(
   parameter int B        = 32,
   parameter int W        = 5,
   parameter int RA_REG   = 31,
   parameter int LINK_OFS = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   input  logic [B-1:0] instruction,
   input  logic [B-1:0] pc_incrementado,
   input  logic         RegWrite,
   input  logic [W-1:0] address_write,
   input  logic [B-1:0] data_write,
   input  logic         flush,
   input  logic         hold,
   output logic         stall_out,
   output logic         out_valid,
   output logic [B-1:0] reg_data1,
   output logic [B-1:0] reg_data2,
   output logic [B-1:0] sgn_extend_data_imm,
   output logic [W-1:0] rs,
   output logic [W-1:0] rt,
   output logic [W-1:0] rd,
   output logic [B-1:0] pc_jump,
   output logic         wb_RegWrite_out,
   output logic         wb_MemtoReg_out,
   output logic         m_Jump_out,
   output logic         m_Branch_out,
   output logic         m_BranchNot_out,
   output logic         m_MemRead_out,
   output logic         m_MemWrite_out,
   output logic         ex_RegDst_out,
   output logic         ex_ALUSrc_out,
   output logic [5:0]   ex_ALUOp_out,
   output logic [5:0]   opcode_out
);

   logic [5:0]   op_in, funct_in;
   logic [W-1:0] rs_in, rt_in, rd_in;
   logic [B-1:0] rs_data, rt_data;
   logic         is_jal, is_jreg, is_jimm;
   logic         hz, take;
   ctrl_t        ctrl_in, ctrl_q;

   logic [B-1:0] nxt_data1, nxt_data2, nxt_imm, nxt_pc_jump;
   logic [W-1:0] nxt_rs, nxt_rt, nxt_rd;
   logic [5:0]   nxt_opcode;
   ctrl_t        nxt_ctrl;

   assign op_in    = instruction[31:26];
   assign funct_in = instruction[5:0];
   assign rs_in    = W'(instruction[25:21]);
   assign rt_in    = W'(instruction[20:16]);
   assign rd_in    = W'(instruction[15:11]);
   assign ctrl_in  = decode_ctrl(op_in, funct_in);
   assign is_jal   = (op_in == OP_JAL);
   assign is_jimm  = (op_in == OP_J) || is_jal;
   assign is_jreg  = (op_in == OP_RTYPE) && ((funct_in == FN_JR) || (funct_in == FN_JALR));

   decode_regfile #(.B(B), .W(W)) u_regfile (
      .clk    (clk),
      .reset  (reset),
      .we     (RegWrite),
      .waddr  (address_write),
      .wdata  (data_write),
      .raddr1 (rs_in),
      .raddr2 (rt_in),
      .rdata1 (rs_data),
      .rdata2 (rt_data)
   );

   // A load in EX whose destination is read by the instruction in ID; r0 never conflicts.
   assign hz = in_valid && out_valid && ctrl_q.mem_read && (rt != '0) &&
               ((rt == rs_in) || ((rt == rt_in) && uses_rt(op_in)));

   assign stall_out = !reset && (hold || (hz && !flush));

   // ID/EX handshake: the register captures a real instruction only when ID
   // presents in_valid, EX is not holding (hold=0) and no hazard or flush
   // squashes it; otherwise a bubble is loaded, except that hold freezes it.
   assign take = in_valid && !flush && !hold && !hz;

   always_comb begin
      nxt_ctrl    = CTRL_NOP;
      nxt_data1   = '0;
      nxt_data2   = '0;
      nxt_imm     = '0;
      nxt_pc_jump = '0;
      nxt_rs      = '0;
      nxt_rt      = '0;
      nxt_rd      = '0;
      nxt_opcode  = '0;
      if (take) begin
         nxt_ctrl    = ctrl_in;
         nxt_data1   = is_jal ? pc_incrementado : rs_data;
         nxt_data2   = is_jal ? B'(LINK_OFS) : rt_data;
         nxt_imm     = {{(B-16){instruction[15]}}, instruction[15:0]};
         nxt_rs      = rs_in;
         nxt_rt      = rt_in;
         nxt_rd      = is_jal ? W'(RA_REG) : rd_in;
         nxt_opcode  = op_in;
         if (is_jimm)      nxt_pc_jump = {pc_incrementado[B-1:28], instruction[25:0], 2'b00};
         else if (is_jreg) nxt_pc_jump = rs_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid           <= 1'b0;
         ctrl_q              <= CTRL_NOP;
         reg_data1           <= '0;
         reg_data2           <= '0;
         sgn_extend_data_imm <= '0;
         pc_jump             <= '0;
         rs                  <= '0;
         rt                  <= '0;
         rd                  <= '0;
         opcode_out          <= '0;
      end else if (flush || !hold) begin
         out_valid           <= take;
         ctrl_q              <= nxt_ctrl;
         reg_data1           <= nxt_data1;
         reg_data2           <= nxt_data2;
         sgn_extend_data_imm <= nxt_imm;
         pc_jump             <= nxt_pc_jump;
         rs                  <= nxt_rs;
         rt                  <= nxt_rt;
         rd                  <= nxt_rd;
         opcode_out          <= nxt_opcode;
      end
   end

   assign wb_RegWrite_out = ctrl_q.reg_write;
   assign wb_MemtoReg_out = ctrl_q.mem_to_reg;
   assign m_Jump_out      = ctrl_q.jump;
   assign m_Branch_out    = ctrl_q.branch;
   assign m_BranchNot_out = ctrl_q.branch_not;
   assign m_MemRead_out   = ctrl_q.mem_read;
   assign m_MemWrite_out  = ctrl_q.mem_write;
   assign ex_RegDst_out   = ctrl_q.reg_dst;
   assign ex_ALUSrc_out   = ctrl_q.alu_src;
   assign ex_ALUOp_out    = ctrl_q.alu_op;

endmodule

// File: tb/tb_decode_stage_hz.sv
// Directed testbench for decode_stage_hz: register file, bypass, load-use
// hazard, jumps and flush/hold/reset priority.
module tb_decode_stage_hz;

   logic        clk, reset, in_valid, RegWrite, flush, hold;
   logic [31:0] instruction, pc_incrementado, data_write;
   logic [4:0]  address_write;
   logic        stall_out, out_valid;
   logic [31:0] reg_data1, reg_data2, sgn_extend_data_imm, pc_jump;
   logic [4:0]  rs, rt, rd;
   logic        wb_RegWrite_out, wb_MemtoReg_out, m_Jump_out, m_Branch_out, m_BranchNot_out;
   logic        m_MemRead_out, m_MemWrite_out, ex_RegDst_out, ex_ALUSrc_out;
   logic [5:0]  ex_ALUOp_out, opcode_out;

   int passed = 0;
   int total  = 0;

   decode_stage_hz dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .instruction(instruction),
      .pc_incrementado(pc_incrementado), .RegWrite(RegWrite), .address_write(address_write),
      .data_write(data_write), .flush(flush), .hold(hold), .stall_out(stall_out),
      .out_valid(out_valid), .reg_data1(reg_data1), .reg_data2(reg_data2),
      .sgn_extend_data_imm(sgn_extend_data_imm), .rs(rs), .rt(rt), .rd(rd), .pc_jump(pc_jump),
      .wb_RegWrite_out(wb_RegWrite_out), .wb_MemtoReg_out(wb_MemtoReg_out),
      .m_Jump_out(m_Jump_out), .m_Branch_out(m_Branch_out), .m_BranchNot_out(m_BranchNot_out),
      .m_MemRead_out(m_MemRead_out), .m_MemWrite_out(m_MemWrite_out),
      .ex_RegDst_out(ex_RegDst_out), .ex_ALUSrc_out(ex_ALUSrc_out),
      .ex_ALUOp_out(ex_ALUOp_out), .opcode_out(opcode_out)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] r_type(input logic [4:0] s, input logic [4:0] t,
                                          input logic [4:0] d, input logic [5:0] fn);
      return {6'h00, s, t, d, 5'h00, fn};
   endfunction

   function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] s,
                                          input logic [4:0] t, input logic [15:0] imm);
      return {op, s, t, imm};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; instruction = '0; pc_incrementado = '0;
      RegWrite = 1'b0; address_write = '0; data_write = '0; flush = 1'b0; hold = 1'b1;
      step(); step();
      total++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b exp 0", out_valid); else passed++;
      total++; if (reg_data1 !== 32'h0) $display("FAIL reset_data1: got %h exp 0", reg_data1); else passed++;
      total++; if (stall_out !== 1'b0) $display("FAIL reset_stall: got %b exp 0", stall_out); else passed++;
      reset = 1'b0; hold = 1'b0;
   endtask

   task automatic test_write_read();
      RegWrite = 1'b1; address_write = 5'd8; data_write = 32'h0000_00AA; in_valid = 1'b0;
      step();
      RegWrite = 1'b0; in_valid = 1'b1; instruction = r_type(5'd8, 5'd0, 5'd3, 6'h20);
      step();
      total++; if (reg_data1 !== 32'hAA) $display("FAIL wr_data1: got %h exp %h", reg_data1, 32'hAA); else passed++;
      total++; if (reg_data2 !== 32'h0) $display("FAIL wr_data2: got %h exp 0", reg_data2); else passed++;
      total++; if (out_valid !== 1'b1) $display("FAIL wr_valid: got %b exp 1", out_valid); else passed++;
      total++; if (ex_RegDst_out !== 1'b1) $display("FAIL wr_regdst: got %b exp 1", ex_RegDst_out); else passed++;
      total++; if (rd !== 5'd3) $display("FAIL wr_rd: got %0d exp 3", rd); else passed++;
      total++; if (ex_ALUOp_out !== 6'h20) $display("FAIL wr_aluop: got %h exp 20", ex_ALUOp_out); else passed++;
   endtask

   task automatic test_bypass();
      instruction = r_type(5'd9, 5'd9, 5'd1, 6'h20);
      RegWrite = 1'b1; address_write = 5'd9; data_write = 32'h0000_1234;
      step();
      total++; if (reg_data1 !== 32'h1234) $display("FAIL byp_data1: got %h exp 1234", reg_data1); else passed++;
      total++; if (reg_data2 !== 32'h1234) $display("FAIL byp_data2: got %h exp 1234", reg_data2); else passed++;
      instruction = r_type(5'd0, 5'd0, 5'd2, 6'h20); address_write = 5'd0; data_write = 32'h0000_FFFF;
      step();
      total++; if (reg_data1 !== 32'h0) $display("FAIL r0_byp_data1: got %h exp 0", reg_data1); else passed++;
      total++; if (reg_data2 !== 32'h0) $display("FAIL r0_byp_data2: got %h exp 0", reg_data2); else passed++;
      RegWrite = 1'b0; instruction = r_type(5'd0, 5'd9, 5'd2, 6'h20);
      step();
      total++; if (reg_data1 !== 32'h0) $display("FAIL r0_read: got %h exp 0", reg_data1); else passed++;
      total++; if (reg_data2 !== 32'h1234) $display("FAIL r9_read: got %h exp 1234", reg_data2); else passed++;
   endtask

   task automatic test_load_use();
      instruction = i_type(6'h23, 5'd2, 5'd5, 16'h0);
      step();
      total++; if (m_MemRead_out !== 1'b1) $display("FAIL lw_memread: got %b exp 1", m_MemRead_out); else passed++;
      total++; if (wb_MemtoReg_out !== 1'b1) $display("FAIL lw_memtoreg: got %b exp 1", wb_MemtoReg_out); else passed++;
      total++; if (rt !== 5'd5) $display("FAIL lw_rt: got %0d exp 5", rt); else passed++;
      instruction = r_type(5'd5, 5'd1, 5'd6, 6'h20);
      #1;
      total++; if (stall_out !== 1'b1) $display("FAIL lu_stall: got %b exp 1", stall_out); else passed++;
      step();
      total++; if (out_valid !== 1'b0) $display("FAIL lu_bubble: got %b exp 0", out_valid); else passed++;
      total++; if (stall_out !== 1'b0) $display("FAIL lu_release: got %b exp 0", stall_out); else passed++;
      step();
      total++; if (out_valid !== 1'b1) $display("FAIL lu_issue_valid: got %b exp 1", out_valid); else passed++;
      total++; if (rd !== 5'd6) $display("FAIL lu_issue_rd: got %0d exp 6", rd); else passed++;

      instruction = i_type(6'h23, 5'd2, 5'd5, 16'h0);
      step();
      instruction = i_type(6'h08, 5'd5, 5'd7, 16'h0001);
      #1;
      total++; if (stall_out !== 1'b1) $display("FAIL lu_addi_stall: got %b exp 1", stall_out); else passed++;
      step(); step();
      total++; if (sgn_extend_data_imm !== 32'h1) $display("FAIL addi_imm: got %h exp 1", sgn_extend_data_imm); else passed++;
      total++; if (ex_ALUSrc_out !== 1'b1) $display("FAIL addi_alusrc: got %b exp 1", ex_ALUSrc_out); else passed++;

      instruction = i_type(6'h23, 5'd2, 5'd5, 16'h0);
      step();
      instruction = i_type(6'h2B, 5'd2, 5'd5, 16'h0);
      #1;
      total++; if (stall_out !== 1'b1) $display("FAIL lu_sw_stall: got %b exp 1", stall_out); else passed++;
      step(); step();
      total++; if (m_MemWrite_out !== 1'b1) $display("FAIL sw_memwrite: got %b exp 1", m_MemWrite_out); else passed++;

      instruction = i_type(6'h23, 5'd2, 5'd5, 16'h0);
      step();
      instruction = i_type(6'h08, 5'd2, 5'd5, 16'hFFFF);
      #1;
      total++; if (stall_out !== 1'b0) $display("FAIL lu_addi_rt_nostall: got %b exp 0", stall_out); else passed++;
      step();
      total++; if (sgn_extend_data_imm !== 32'hFFFF_FFFF) $display("FAIL addi_sext: got %h exp ffffffff", sgn_extend_data_imm); else passed++;

      instruction = i_type(6'h23, 5'd2, 5'd0, 16'h0);
      step();
      instruction = r_type(5'd0, 5'd0, 5'd6, 6'h20);
      #1;
      total++; if (stall_out !== 1'b0) $display("FAIL lu_r0_nostall: got %b exp 0", stall_out); else passed++;
      step();
      total++; if (out_valid !== 1'b1) $display("FAIL lu_r0_issue: got %b exp 1", out_valid); else passed++;
   endtask

   task automatic test_jal();
      pc_incrementado = 32'h0040_0008;
      instruction = {6'h03, 26'h000010};
      step();
      total++; if (pc_jump !== 32'h0000_0040) $display("FAIL jal_target: got %h exp 00000040", pc_jump); else passed++;
      total++; if (rd !== 5'd31) $display("FAIL jal_rd: got %0d exp 31", rd); else passed++;
      total++; if (reg_data1 !== 32'h0040_0008) $display("FAIL jal_data1: got %h exp 00400008", reg_data1); else passed++;
      total++; if (reg_data2 !== 32'h4) $display("FAIL jal_data2: got %h exp 4", reg_data2); else passed++;
      total++; if (m_Jump_out !== 1'b1) $display("FAIL jal_jump: got %b exp 1", m_Jump_out); else passed++;
      total++; if (wb_RegWrite_out !== 1'b1) $display("FAIL jal_regwrite: got %b exp 1", wb_RegWrite_out); else passed++;
      pc_incrementado = '0;
   endtask

   task automatic test_jr();
      in_valid = 1'b0; RegWrite = 1'b1; address_write = 5'd31; data_write = 32'h0040_0100;
      step();
      RegWrite = 1'b0; in_valid = 1'b1; instruction = r_type(5'd31, 5'd0, 5'd0, 6'h08);
      step();
      total++; if (pc_jump !== 32'h0040_0100) $display("FAIL jr_target: got %h exp 00400100", pc_jump); else passed++;
      total++; if (m_Jump_out !== 1'b1) $display("FAIL jr_jump: got %b exp 1", m_Jump_out); else passed++;
      total++; if (wb_RegWrite_out !== 1'b0) $display("FAIL jr_regwrite: got %b exp 0", wb_RegWrite_out); else passed++;
      total++; if (rd !== 5'd0) $display("FAIL jr_rd: got %0d exp 0", rd); else passed++;
      RegWrite = 1'b1; address_write = 5'd31; data_write = 32'h0040_0200;
      step();
      total++; if (pc_jump !== 32'h0040_0200) $display("FAIL jr_bypass: got %h exp 00400200", pc_jump); else passed++;
      RegWrite = 1'b0;
   endtask

   task automatic test_flush_hold();
      instruction = i_type(6'h23, 5'd2, 5'd5, 16'h0);
      step();
      instruction = r_type(5'd5, 5'd1, 5'd6, 6'h20); flush = 1'b1;
      #1;
      total++; if (stall_out !== 1'b0) $display("FAIL flush_stall: got %b exp 0", stall_out); else passed++;
      step();
      total++; if (out_valid !== 1'b0) $display("FAIL flush_bubble: got %b exp 0", out_valid); else passed++;
      total++; if (m_MemRead_out !== 1'b0) $display("FAIL flush_ctrl: got %b exp 0", m_MemRead_out); else passed++;
      flush = 1'b0;

      instruction = r_type(5'd8, 5'd0, 5'd3, 6'h20);
      step();
      hold = 1'b1; instruction = r_type(5'd9, 5'd9, 5'd1, 6'h22);
      #1;
      total++; if (stall_out !== 1'b1) $display("FAIL hold_stall: got %b exp 1", stall_out); else passed++;
      for (int i = 0; i < 3; i++) begin
         step();
         total++; if (reg_data1 !== 32'hAA) $display("FAIL hold_data1[%0d]: got %h exp aa", i, reg_data1); else passed++;
         total++; if (rd !== 5'd3) $display("FAIL hold_rd[%0d]: got %0d exp 3", i, rd); else passed++;
         total++; if (ex_ALUOp_out !== 6'h20) $display("FAIL hold_aluop[%0d]: got %h exp 20", i, ex_ALUOp_out); else passed++;
         total++; if (stall_out !== 1'b1) $display("FAIL hold_stall[%0d]: got %b exp 1", i, stall_out); else passed++;
      end
      #2 reset = 1'b1;
      #1;
      total++; if (out_valid !== 1'b0) $display("FAIL rst_hold_valid: got %b exp 0", out_valid); else passed++;
      total++; if (reg_data1 !== 32'h0) $display("FAIL rst_hold_data1: got %h exp 0", reg_data1); else passed++;
      total++; if (rd !== 5'd0) $display("FAIL rst_hold_rd: got %0d exp 0", rd); else passed++;
      total++; if (stall_out !== 1'b0) $display("FAIL rst_hold_stall: got %b exp 0", stall_out); else passed++;
      total++; if (wb_RegWrite_out !== 1'b0) $display("FAIL rst_hold_regwrite: got %b exp 0", wb_RegWrite_out); else passed++;
      #1 reset = 1'b0; hold = 1'b0;
      instruction = r_type(5'd8, 5'd0, 5'd3, 6'h20);
      step();
      total++; if (out_valid !== 1'b1) $display("FAIL post_rst_valid: got %b exp 1", out_valid); else passed++;
      total++; if (reg_data1 !== 32'h0) $display("FAIL post_rst_r8: got %h exp 0", reg_data1); else passed++;
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_bypass();
      test_load_use();
      test_jal();
      test_jr();
      test_flush_hold();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
